// File: rtl/clock_set_controller_if.sv
// rtl/clock_set_controller_if.sv - button/tick inputs and counter/display controls of the clock-set controller
// Signals:
//   i_Mode_Pulse, i_Inc_Pulse, i_Tick_1Hz : one-cycle pulses into the controller
//   o_Run_Enable                          : seconds counter gate (high only in RUN)
//   o_Inc_Hours, o_Inc_Minutes            : one-cycle increment requests to the time counters
//   o_Clear_Seconds                       : one-cycle seconds clear on leaving set mode
//   o_Blink_Hours, o_Blink_Minutes        : blank request for the digits being edited
//   o_State                               : 0 RUN, 1 SET_HOURS, 2 SET_MINUTES
// Modports: master drives the pulses and observes the controls, slave is the controller.
interface clock_set_controller_if;
    logic       i_Mode_Pulse;
    logic       i_Inc_Pulse;
    logic       i_Tick_1Hz;
    logic       o_Run_Enable;
    logic       o_Inc_Hours;
    logic       o_Inc_Minutes;
    logic       o_Clear_Seconds;
    logic       o_Blink_Hours;
    logic       o_Blink_Minutes;
    logic [1:0] o_State;

    modport master (
        output i_Mode_Pulse, i_Inc_Pulse, i_Tick_1Hz,
        input  o_Run_Enable, o_Inc_Hours, o_Inc_Minutes, o_Clear_Seconds,
        input  o_Blink_Hours, o_Blink_Minutes, o_State
    );

    modport slave (
        input  i_Mode_Pulse, i_Inc_Pulse, i_Tick_1Hz,
        output o_Run_Enable, o_Inc_Hours, o_Inc_Minutes, o_Clear_Seconds,
        output o_Blink_Hours, o_Blink_Minutes, o_State
    );
endinterface

// File: rtl/clock_set_controller.sv
// rtl/clock_set_controller.sv - RUN / SET_HOURS / SET_MINUTES sequencer with blink and optional auto-exit
// Ports:
//   i_Clock   : system clock, rising edge
//   i_Reset_n : synchronous active-low reset
//   bus       : clock_set_controller_if.slave (button pulses, 1 Hz tick, counter and display controls)
// Parameters:
//   TIMEOUT_S    : idle 1 Hz ticks before a set mode falls back to RUN
//   BLINK_CYCLES : clock cycles per blink half-period (>= 2)
// Build option: CLOCK_SET_TIMEOUT_EN adds the inactivity timeout; without it set modes exit only via MODE.
module clock_set_controller #(
    parameter int TIMEOUT_S    = 10,
    parameter int BLINK_CYCLES = 25_000_000
) (
    input  logic                   i_Clock,
    input  logic                   i_Reset_n,
    clock_set_controller_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_RUN         = 2'd0,
        ST_SET_HOURS   = 2'd1,
        ST_SET_MINUTES = 2'd2,
        ST_ILLEGAL     = 2'd3
    } state_e;

    localparam int                 BLINK_W    = $clog2(BLINK_CYCLES);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYCLES - 1);

    state_e             state_q, state_d;
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               phase_q, phase_d;
    logic               run_enable_q, run_enable_d;
    logic               inc_hours_q, inc_hours_d;
    logic               inc_minutes_q, inc_minutes_d;
    logic               clear_seconds_q, clear_seconds_d;
    logic               blink_hours_q, blink_hours_d;
    logic               blink_minutes_q, blink_minutes_d;
    logic               inc_accept;

`ifdef CLOCK_SET_TIMEOUT_EN
    localparam int               TMO_W    = $clog2(TIMEOUT_S + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_S);

    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic [TMO_W-1:0] tmo_next;
    logic             in_set;
`else
    logic unused_tick;
    assign unused_tick = bus.i_Tick_1Hz;
`endif

    always_comb begin
        state_d         = state_q;
        inc_hours_d     = 1'b0;
        inc_minutes_d   = 1'b0;
        clear_seconds_d = 1'b0;
        inc_accept      = 1'b0;

        // MODE is tested first in every state so a simultaneous INC is dropped.
        case (state_q)
            ST_RUN: begin
                if (bus.i_Mode_Pulse) begin
                    state_d = ST_SET_HOURS;
                end
            end
            ST_SET_HOURS: begin
                if (bus.i_Mode_Pulse) begin
                    state_d = ST_SET_MINUTES;
                end else if (bus.i_Inc_Pulse) begin
                    inc_hours_d = 1'b1;
                    inc_accept  = 1'b1;
                end
            end
            ST_SET_MINUTES: begin
                if (bus.i_Mode_Pulse) begin
                    state_d         = ST_RUN;
                    clear_seconds_d = 1'b1;
                end else if (bus.i_Inc_Pulse) begin
                    inc_minutes_d = 1'b1;
                    inc_accept    = 1'b1;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

`ifdef CLOCK_SET_TIMEOUT_EN
        // Any accepted button resets the idle count, which also gives buttons
        // priority over a terminal tick landing in the same cycle.
        in_set    = (state_q == ST_SET_HOURS) || (state_q == ST_SET_MINUTES);
        tmo_next  = tmo_cnt_q + TMO_W'(1);
        tmo_cnt_d = tmo_cnt_q;
        if (!in_set || bus.i_Mode_Pulse || inc_accept) begin
            tmo_cnt_d = '0;
        end else if (bus.i_Tick_1Hz) begin
            if (tmo_next == TMO_LAST) begin
                tmo_cnt_d       = '0;
                state_d         = ST_RUN;
                clear_seconds_d = 1'b1;
            end else begin
                tmo_cnt_d = tmo_next;
            end
        end
`endif

        // Restarting the blink on state change or INC keeps the edited digits
        // visible for a full half-period right after the user acts.
        blink_cnt_d = blink_cnt_q;
        phase_d     = phase_q;
        if ((state_d != state_q) || inc_accept) begin
            blink_cnt_d = '0;
            phase_d     = 1'b0;
        end else if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = '0;
            phase_d     = ~phase_q;
        end else begin
            blink_cnt_d = blink_cnt_q + BLINK_W'(1);
        end

        // Outputs are decoded from next-state values so they line up with o_State.
        run_enable_d    = (state_d == ST_RUN);
        blink_hours_d   = (state_d == ST_SET_HOURS) && phase_d;
        blink_minutes_d = (state_d == ST_SET_MINUTES) && phase_d;
    end

    always_ff @(posedge i_Clock) begin
        if (!i_Reset_n) begin
            state_q         <= ST_RUN;
            blink_cnt_q     <= '0;
            phase_q         <= 1'b0;
            run_enable_q    <= 1'b1;
            inc_hours_q     <= 1'b0;
            inc_minutes_q   <= 1'b0;
            clear_seconds_q <= 1'b0;
            blink_hours_q   <= 1'b0;
            blink_minutes_q <= 1'b0;
`ifdef CLOCK_SET_TIMEOUT_EN
            tmo_cnt_q       <= '0;
`endif
        end else begin
            state_q         <= state_d;
            blink_cnt_q     <= blink_cnt_d;
            phase_q         <= phase_d;
            run_enable_q    <= run_enable_d;
            inc_hours_q     <= inc_hours_d;
            inc_minutes_q   <= inc_minutes_d;
            clear_seconds_q <= clear_seconds_d;
            blink_hours_q   <= blink_hours_d;
            blink_minutes_q <= blink_minutes_d;
`ifdef CLOCK_SET_TIMEOUT_EN
            tmo_cnt_q       <= tmo_cnt_d;
`endif
        end
    end

    assign bus.o_State         = state_q;
    assign bus.o_Run_Enable    = run_enable_q;
    assign bus.o_Inc_Hours     = inc_hours_q;
    assign bus.o_Inc_Minutes   = inc_minutes_q;
    assign bus.o_Clear_Seconds = clear_seconds_q;
    assign bus.o_Blink_Hours   = blink_hours_q;
    assign bus.o_Blink_Minutes = blink_minutes_q;

endmodule

// File: doc/clock_set_controller.md
# clock_set_controller

Time-setting controller for the clock. It consumes the one-cycle release pulses produced by the `button_debounce` instances on the MODE and INC buttons. It sequences the hours/minutes counters through run and set modes, and drives the blink enables for the display digit being edited. It sits between the debounced buttons and the timekeeping counters/display mux.

## Interface
- `TIMEOUT_S`, 10: number of `i_Tick_1Hz` pulses with no button activity after which a set mode exits to RUN.
- `BLINK_CYCLES`, 25_000_000: clock cycles per blink half-period; must be ≥ 2.
- `i_Clock` input 1: system clock; all logic on rising edge.
- `i_Reset_n` input 1: synchronous, active-low reset.
- `i_Mode_Pulse` input 1: one-cycle pulse on debounced MODE release.
- `i_Inc_Pulse` input 1: one-cycle pulse on debounced INC release.
- `i_Tick_1Hz` input 1: one-cycle seconds tick from the timebase.
- `o_Run_Enable` output 1: high only in RUN; gates the seconds counter.
- `o_Inc_Hours` output 1: one-cycle pulse; increment the hours counter.
- `o_Inc_Minutes` output 1: one-cycle pulse; increment the minutes counter.
- `o_Clear_Seconds` output 1: one-cycle pulse; zero the seconds counter.
- `o_Blink_Hours` output 1: high means blank the hours digits.
- `o_Blink_Minutes` output 1: high means blank the minutes digits.
- `o_State` output 2: current state (0 RUN, 1 SET_HOURS, 2 SET_MINUTES).

## Operation
- Three-state FSM; encoding 3 is illegal and recovers to RUN on the next clock.
- RUN:
  - MODE goes to SET_HOURS.
  - INC is ignored.
- SET_HOURS:
  - INC pulses `o_Inc_Hours`.
  - MODE goes to SET_MINUTES.
- SET_MINUTES:
  - INC pulses `o_Inc_Minutes`.
  - MODE goes to RUN and pulses `o_Clear_Seconds`.
- If MODE and INC arrive in the same cycle, MODE wins and the INC is discarded (no increment pulse).
- The controller only requests increments. Wrap-around (23→0, 59→0) belongs to the counters, and no carry from minutes into hours is requested.
- Timeout counter:
  - `ceil(log2(TIMEOUT_S+1))` bits.
  - Cleared on entry to any set state and on every accepted MODE or INC pulse.
  - Increments on `i_Tick_1Hz` while in a set state.
  - On reaching `TIMEOUT_S`, the FSM returns to RUN and pulses `o_Clear_Seconds`.
  - A button pulse in the same cycle as the terminal tick takes priority over the timeout.
- Blink:
  - A free-running counter (0..BLINK_CYCLES-1) toggles a phase bit on wrap.
  - Counter and phase are reset to 0 on every state change, so the edited digits always start visible.
  - `o_Blink_Hours` = SET_HOURS & phase; `o_Blink_Minutes` = SET_MINUTES & phase.
  - Blanking is suppressed for one full half-period after any INC pulse (phase forced to 0 and the counter cleared).
- `o_Run_Enable` is 0 in both set states; the timebase keeps ticking, but the seconds do not advance.

## Timing
- All outputs are registered.
- Reset values: `o_State`=0, `o_Run_Enable`=1, all pulses 0, both blink outputs 0, timeout and blink counters 0.
- Latency: a pulse input at edge N yields the state change or output pulse visible after edge N+1 (one cycle). Each output pulse is exactly one cycle wide.
- `o_Run_Enable` deasserts in the same cycle `o_State` leaves RUN.
- Reset asserted mid-operation (including mid-timeout or mid-blink) returns to RUN at the next edge; pending pulses are dropped.
- Back-to-back input pulses on consecutive cycles are each honoured; no input is lost except under the simultaneous MODE+INC rule.

## Configuration
- Macro `CLOCK_SET_TIMEOUT_EN`.
- Defined: the timeout counter and auto-exit described above are present.
- Undefined:
  - No timeout logic is synthesized and `i_Tick_1Hz` is unused.
  - Set modes exit only via MODE.
  - `TIMEOUT_S` is ignored.
  - All other behaviour is unchanged.

## Test plan
Bench parameters: `TIMEOUT_S`=3, `BLINK_CYCLES`=4, 10 ns clock.
- Reset, then three MODE pulses spaced 5 cycles apart → `o_State` 0→1→2→0. `o_Run_Enable` is 1,0,0,1. Exactly one `o_Clear_Seconds` pulse, one cycle after the third MODE.
- In SET_HOURS, 5 INC pulses → 5 one-cycle `o_Inc_Hours` pulses, each one cycle after its input; `o_Inc_Minutes` stays 0.
- In SET_MINUTES, MODE and INC in the same cycle → state 0, no `o_Inc_Minutes` pulse, one `o_Clear_Seconds` pulse.
- With the macro defined, enter SET_HOURS and give 3 `i_Tick_1Hz` with no buttons → state 0 after the third tick plus one cycle, with an `o_Clear_Seconds` pulse. Repeat with an INC between ticks 2 and 3 → still in SET_HOURS after tick 3. With the macro undefined → remains in SET_HOURS indefinitely.
- In SET_HOURS with no input:
  - `o_Blink_Hours` reads 0×4 cycles, then 1×4 cycles, repeating.
  - `o_Blink_Minutes` stays 0.
  - An INC during the blank phase forces 0 for the next 4 cycles.
- Drive `i_Reset_n` low for one cycle while in SET_MINUTES mid-blink → next cycle `o_State`=0, `o_Run_Enable`=1, blink outputs 0, no pulses.
